// File: rtl/video_ports_rd_pkg.sv
// Shared constants and types for the video port read-back path.
package video_ports_rd_pkg;

    // Register select values for the read-back port
    localparam logic [3:0] ADDR_STATUS    = 4'd0;
    localparam logic [3:0] ADDR_VCNT_L    = 4'd1;
    localparam logic [3:0] ADDR_VCNT_H    = 4'd2;
    localparam logic [3:0] ADDR_HCNT      = 4'd3;
    localparam logic [3:0] ADDR_BORDER    = 4'd4;
    localparam logic [3:0] ADDR_VPAGE     = 4'd5;
    localparam logic [3:0] ADDR_VCONF     = 4'd6;
    localparam logic [3:0] ADDR_PALSEL    = 4'd7;
    localparam logic [3:0] ADDR_FRAME_CNT = 4'd8;

    // STATUS byte layout
    localparam int ST_FRAME  = 0;
    localparam int ST_LINE   = 1;
    localparam int ST_DMA    = 2;
    localparam int ST_VBLANK = 6;
    localparam int ST_OVF    = 7;

    localparam logic [8:0] VBLANK_LINE_DEF = 9'd288;
    localparam logic [7:0] UNUSED_VAL_DEF  = 8'hFF;

    // A sampled read request
    typedef struct packed {
        logic       vld;
        logic [3:0] addr;
    } rd_req_t;

    // Assemble the STATUS byte from its fields
    function automatic logic [7:0] status_byte(input logic ovf, input logic vblank,
                                               input logic [2:0] pending);
        logic [7:0] s;
        s                = 8'h00;
        s[ST_OVF]        = ovf;
        s[ST_VBLANK]     = vblank;
        s[ST_FRAME]      = pending[ST_FRAME];
        s[ST_LINE]       = pending[ST_LINE];
        s[ST_DMA]        = pending[ST_DMA];
        return s;
    endfunction

endpackage

// File: rtl/video_ports_rd_int_flags.sv
// Sticky interrupt-pending flags with clear-on-read, overflow flag and int_req.
module video_int_flags (
    input  logic       clk,
    input  logic       res,
    input  logic [2:0] ev,        // {dma, line, frame} 1-cycle events
    input  logic       clr,       // STATUS read this cycle
    input  logic [2:0] int_mask,
    output logic [2:0] pending,
    output logic       ovf,
    output logic       int_req
);

    logic [2:0] pending_nxt;
    logic       ovf_nxt;

    // Next flag state: a clearing read keeps only this cycle's events so none are lost,
    // and an event coinciding with the clear never counts as an overflow.
    always_comb begin
        pending_nxt = pending | ev;
        ovf_nxt     = ovf | (|(ev & pending));
        if (clr) begin
            pending_nxt = ev;
            ovf_nxt     = 1'b0;
        end
    end

    // Flag registers; int_req follows the registered pending/mask one cycle later
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pending <= 3'b000;
            ovf     <= 1'b0;
            int_req <= 1'b0;
        end else begin
            pending <= pending_nxt;
            ovf     <= ovf_nxt;
            int_req <= |(pending & int_mask);
        end
    end

endmodule

// File: rtl/video_ports_rd.sv
// Z80 read-back of video parameters, raster position, frame counter and interrupt status.
module video_ports_rd
    import video_ports_rd_pkg::*;
#(
    parameter logic [7:0] UNUSED_VAL  = UNUSED_VAL_DEF,
    parameter logic [8:0] VBLANK_LINE = VBLANK_LINE_DEF
) (
    input  logic       clk,
    input  logic       res,
    input  logic       rd_req,
    input  logic [3:0] addr,
    output logic [7:0] dout,
    input  logic [8:0] vcnt,
    input  logic [7:0] hcnt,
    input  logic       frame_int,
    input  logic       line_int,
    input  logic       dma_int,
    input  logic [2:0] int_mask,
    input  logic [7:0] border,
    input  logic [7:0] vpage,
    input  logic [7:0] vconf,
    input  logic [7:0] palsel,
    output logic       int_req
);

    rd_req_t    req;
    logic [2:0] pending;
    logic       ovf;
    logic       vblank;
    logic       snap_v;
    logic [7:0] snap_h;
    logic [7:0] frame_cnt;
    logic [7:0] rd_data;
    logic       status_rd;
    logic       vcntl_rd;

    assign req       = '{vld: rd_req, addr: addr};
    assign vblank    = (vcnt >= VBLANK_LINE);
    assign status_rd = req.vld && (req.addr == ADDR_STATUS);
    assign vcntl_rd  = req.vld && (req.addr == ADDR_VCNT_L);

    video_int_flags u_flags (
        .clk      (clk),
        .res      (res),
        .ev       ({dma_int, line_int, frame_int}),
        .clr      (status_rd),
        .int_mask (int_mask),
        .pending  (pending),
        .ovf      (ovf),
        .int_req  (int_req)
    );

    // Read mux: values as seen in the strobe cycle (STATUS shows pre-clear flags)
    always_comb begin
        rd_data = UNUSED_VAL;
        case (req.addr)
            ADDR_STATUS:    rd_data = status_byte(ovf, vblank, pending);
            ADDR_VCNT_L:    rd_data = vcnt[7:0];
            ADDR_VCNT_H:    rd_data = {7'b0, snap_v};
            ADDR_HCNT:      rd_data = snap_h;
            ADDR_BORDER:    rd_data = border;
            ADDR_VPAGE:     rd_data = vpage;
            ADDR_VCONF:     rd_data = vconf;
            ADDR_PALSEL:    rd_data = palsel;
            ADDR_FRAME_CNT: rd_data = frame_cnt;
            default:        rd_data = UNUSED_VAL;
        endcase
    end

    // Read data register, loaded only on a strobe and held otherwise
    always_ff @(posedge clk or posedge res) begin
        if (res)          dout <= 8'h00;
        else if (req.vld) dout <= rd_data;
    end

    // Raster snapshot: taken only on a VCNT_L read so VCNT_H/HCNT pair with it coherently
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            snap_v <= 1'b0;
            snap_h <= 8'h00;
        end else if (vcntl_rd) begin
            snap_v <= vcnt[8];
            snap_h <= hcnt;
        end
    end

    // Free-running frame counter, wraps naturally at 8 bits
    always_ff @(posedge clk or posedge res) begin
        if (res)            frame_cnt <= 8'h00;
        else if (frame_int) frame_cnt <= frame_cnt + 8'd1;
    end

endmodule

// File: tb/tb_video_ports_rd.sv
// Scoreboard bench for video_ports_rd: expected read data queued at strobe, checked at response.
module tb_video_ports_rd;
    logic       clk = 1'b0;
    logic       res;
    logic       rd_req;
    logic [3:0] addr;
    logic [7:0] dout;
    logic [8:0] vcnt;
    logic [7:0] hcnt;
    logic       frame_int, line_int, dma_int;
    logic [2:0] int_mask;
    logic [7:0] border, vpage, vconf, palsel;
    logic       int_req;

    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] fc = 8'h00;   // model of the frame counter

    video_ports_rd dut (
        .clk(clk), .res(res), .rd_req(rd_req), .addr(addr), .dout(dout),
        .vcnt(vcnt), .hcnt(hcnt), .frame_int(frame_int), .line_int(line_int),
        .dma_int(dma_int), .int_mask(int_mask), .border(border), .vpage(vpage),
        .vconf(vconf), .palsel(palsel), .int_req(int_req)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one read, queue its expectation, and score the response a cycle later
    task automatic rd_and_score(input logic [3:0] a, input logic [7:0] e, input string nm);
        logic [7:0] x;
        exp_q.push_back(e);
        rd_req = 1'b1;
        addr   = a;
        cyc();
        rd_req = 1'b0;
        x = exp_q.pop_front();
        n_checks++;
        if (dout !== x) begin
            n_fail++;
            $display("FAIL %s: dout=%h expected %h", nm, dout, x);
        end
    endtask

    task automatic pulse(input logic [2:0] ev);
        {dma_int, line_int, frame_int} = ev;
        if (ev[0]) fc = fc + 8'd1;
        cyc();
        {dma_int, line_int, frame_int} = 3'b000;
    endtask

    task automatic test_reset();
        res = 1'b1; rd_req = 1'b0; addr = 4'd0; vcnt = 9'd0; hcnt = 8'd0;
        {dma_int, line_int, frame_int} = 3'b000; int_mask = 3'b000;
        border = 8'h00; vpage = 8'h00; vconf = 8'h00; palsel = 8'h00;
        #3;
        n_checks++;
        if (dout !== 8'h00 || int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: dout=%h int_req=%b expected 00/0", dout, int_req);
        end
        cyc(); cyc();
        res = 1'b0;
        cyc();
        rd_and_score(4'd0,  8'h00, "rst_status");
        rd_and_score(4'd2,  8'h00, "rst_vcnt_h");
        rd_and_score(4'd3,  8'h00, "rst_hcnt");
        rd_and_score(4'd8,  8'h00, "rst_frame_cnt");
        rd_and_score(4'd12, 8'hFF, "unused_12");
        rd_and_score(4'd9,  8'hFF, "unused_9");
        rd_and_score(4'd15, 8'hFF, "unused_15");
    endtask

    task automatic test_params();
        logic [7:0] x;
        border = 8'h11; vpage = 8'h22; vconf = 8'h33; palsel = 8'h44;
        rd_and_score(4'd4, 8'h11, "border");
        rd_and_score(4'd5, 8'h22, "vpage");
        rd_and_score(4'd6, 8'h33, "vconf");
        rd_and_score(4'd7, 8'h44, "palsel");
        // dout must hold between strobes
        border = 8'h99;
        cyc(); cyc();
        n_checks++;
        if (dout !== 8'h44) begin
            n_fail++;
            $display("FAIL dout_hold: dout=%h expected 44", dout);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x;
        exp_q.push_back(8'h99);
        exp_q.push_back(8'h44);
        rd_req = 1'b1; addr = 4'd4;
        cyc();
        addr = 4'd7;
        x = exp_q.pop_front();
        n_checks++;
        if (dout !== x) begin
            n_fail++;
            $display("FAIL b2b_first: dout=%h expected %h", dout, x);
        end
        cyc();
        rd_req = 1'b0;
        x = exp_q.pop_front();
        n_checks++;
        if (dout !== x) begin
            n_fail++;
            $display("FAIL b2b_second: dout=%h expected %h", dout, x);
        end
    endtask

    task automatic test_vblank();
        vcnt = 9'd287; rd_and_score(4'd0, 8'h00, "vblank_287");
        vcnt = 9'd288; rd_and_score(4'd0, 8'h40, "vblank_288");
        vcnt = 9'd319; rd_and_score(4'd0, 8'h40, "vblank_319");
        vcnt = 9'd0;
    endtask

    task automatic test_line_int();
        int_mask = 3'b010;
        pulse(3'b010);
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL int_req_early: int_req=%b expected 0", int_req);
        end
        cyc();
        n_checks++;
        if (int_req !== 1'b1) begin
            n_fail++;
            $display("FAIL int_req_set: int_req=%b expected 1", int_req);
        end
        rd_and_score(4'd0, 8'h02, "line_status");
        rd_and_score(4'd0, 8'h00, "line_cleared");
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL int_req_drop: int_req=%b expected 0", int_req);
        end
    endtask

    task automatic test_dma_masked();
        pulse(3'b100);
        cyc(); cyc();
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL dma_masked: int_req=%b expected 0", int_req);
        end
        rd_and_score(4'd0, 8'h04, "dma_status");
        rd_and_score(4'd0, 8'h00, "dma_cleared");
    endtask

    task automatic test_overflow();
        pulse(3'b001);
        pulse(3'b001);
        rd_and_score(4'd0, 8'h81, "ovf_status");
        rd_and_score(4'd0, 8'h00, "ovf_cleared");
    endtask

    task automatic test_coincident();
        line_int = 1'b1;
        rd_and_score(4'd0, 8'h00, "coinc_read");
        line_int = 1'b0;
        rd_and_score(4'd0, 8'h02, "coinc_kept");
        // the kept bit followed by a new line event in the clearing cycle: no ovf
        line_int = 1'b1;
        rd_and_score(4'd0, 8'h00, "coinc_again");
        line_int = 1'b0;
        rd_and_score(4'd0, 8'h02, "coinc_no_ovf");
    endtask

    task automatic test_snapshot();
        vcnt = 9'h12C; hcnt = 8'h5A;
        rd_and_score(4'd1, 8'h2C, "vcnt_l");
        vcnt = 9'h005; hcnt = 8'h77;
        rd_and_score(4'd2, 8'h01, "vcnt_h_snap");
        rd_and_score(4'd3, 8'h5A, "hcnt_snap");
        rd_and_score(4'd1, 8'h05, "vcnt_l_2");
        rd_and_score(4'd2, 8'h00, "vcnt_h_snap2");
        rd_and_score(4'd3, 8'h77, "hcnt_snap2");
    endtask

    task automatic test_frame_cnt_reset();
        rd_and_score(4'd8, fc, "frame_cnt_now");
        int_mask = 3'b001;
        for (int i = 0; i < 10; i++) pulse(3'b001);
        rd_and_score(4'd8, fc, "frame_cnt_10");
        n_checks++;
        if (int_req !== 1'b1) begin
            n_fail++;
            $display("FAIL int_req_frame: int_req=%b expected 1", int_req);
        end
        // asynchronous reset with a read strobe in flight
        rd_req = 1'b1; addr = 4'd8;
        #2;
        res = 1'b1;
        #1;
        n_checks++;
        if (dout !== 8'h00 || int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: dout=%h int_req=%b expected 00/0", dout, int_req);
        end
        fc = 8'h00;
        cyc();
        rd_req = 1'b0; res = 1'b0;
        cyc();
        n_checks++;
        if (dout !== 8'h00) begin
            n_fail++;
            $display("FAIL rd_discarded: dout=%h expected 00", dout);
        end
        rd_and_score(4'd0, 8'h00, "status_after_rst");
        frame_int = 1'b1;
        for (int i = 0; i < 255; i++) begin
            fc = fc + 8'd1;
            cyc();
        end
        frame_int = 1'b0;
        rd_and_score(4'd8, 8'hFF, "frame_cnt_ff");
        pulse(3'b001);
        rd_and_score(4'd8, 8'h00, "frame_cnt_wrap");
        rd_and_score(4'd8, fc, "frame_cnt_model");
    endtask

    initial begin
        test_reset();
        test_params();
        test_back_to_back();
        test_vblank();
        test_line_int();
        test_dma_masked();
        test_overflow();
        test_coincident();
        test_snapshot();
        test_frame_cnt_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
